booth_controller: RTL and testbench

- Moore FSM that sequences a radix-2 Booth multiplication over the shared add/sub/init adder and the A/Q/Q-1 shift registers.
- Issues one init, then REG_WIDTH test/arith/shift iterations, then a one-cycle done pulse.
- Sits between the top-level start/done handshake and the Booth datapath. The controller holds no operand data; it decides from the Q[0] and Q[-1] bits the datapath feeds back to it.

---
 rtl/booth_controller.sv | 167 ++++++++++++++++
 tb/tb_booth_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplication sequencer: one init, REG_WIDTH test/arith/shift iterations, then a done pulse.
// Define BOOTH_CTL_ABORT_EN to add an abort input that returns a busy sequence to IDLE.
module booth_controller #(
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef BOOTH_CTL_ABORT_EN
    input  logic abort,
`endif
    input  logic q0,
    input  logic q_m1,
    output logic ctl_init,
    output logic ctl_load,
    output logic ctl_add,
    output logic ctl_sub,
    output logic ctl_shift,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_WIDTH = $clog2(REG_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ARITH = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 abort_c;
    logic                 in_seq_c;

    logic ctl_init_d, ctl_load_d, ctl_add_d, ctl_sub_d, ctl_shift_d, busy_d, done_d;

`ifdef BOOTH_CTL_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign in_seq_c = (state_q == S_INIT) || (state_q == S_TEST) ||
                      (state_q == S_ARITH) || (state_q == S_SHIFT);

    // Next-state, operation and iteration counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                cnt_d   = CNT_WIDTH'(REG_WIDTH);
                state_d = S_TEST;
            end
            S_TEST: begin
                case ({q0, q_m1})
                    2'b10: begin
                        op_d    = OP_SUB;
                        state_d = S_ARITH;
                    end
                    2'b01: begin
                        op_d    = OP_ADD;
                        state_d = S_ARITH;
                    end
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ARITH: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d   = cnt_q - CNT_WIDTH'(1);
                state_d = (cnt_q == CNT_WIDTH'(1)) ? S_DONE : S_TEST;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_c && in_seq_c) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are registered copies of the decode of the upcoming state
    always_comb begin
        ctl_init_d  = 1'b0;
        ctl_load_d  = 1'b0;
        ctl_add_d   = 1'b0;
        ctl_sub_d   = 1'b0;
        ctl_shift_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_INIT: begin
                ctl_init_d = 1'b1;
                ctl_load_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_TEST: begin
                busy_d = 1'b1;
            end
            S_ARITH: begin
                ctl_add_d = 1'b1;
                ctl_sub_d = (op_d == OP_SUB);
                busy_d    = 1'b1;
            end
            S_SHIFT: begin
                ctl_shift_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            cnt_q     <= '0;
            ctl_init  <= 1'b0;
            ctl_load  <= 1'b0;
            ctl_add   <= 1'b0;
            ctl_sub   <= 1'b0;
            ctl_shift <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            ctl_init  <= ctl_init_d;
            ctl_load  <= ctl_load_d;
            ctl_add   <= ctl_add_d;
            ctl_sub   <= ctl_sub_d;
            ctl_shift <= ctl_shift_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // A shift with an exhausted counter would mean the iteration count was lost
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_SHIFT) |-> (cnt_q != '0));

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller with a behavioural 8-bit Booth datapath closing the q0/q_m1 loop.
// Abort scenario is exercised when BOOTH_CTL_ABORT_EN is defined.
module tb_booth_controller;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic q0, q_m1;
    logic ctl_init, ctl_load, ctl_add, ctl_sub, ctl_shift, busy, done;
`ifdef BOOTH_CTL_ABORT_EN
    logic abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_controller #(.REG_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef BOOTH_CTL_ABORT_EN
        .abort     (abort),
`endif
        .q0        (q0),
        .q_m1      (q_m1),
        .ctl_init  (ctl_init),
        .ctl_load  (ctl_load),
        .ctl_add   (ctl_add),
        .ctl_sub   (ctl_sub),
        .ctl_shift (ctl_shift),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural datapath: M, A, Q, Q-1 driven by the controller outputs
    logic [7:0] op_m, op_q;
    logic [7:0] dp_m, dp_a, dp_q;
    logic       dp_qm1;
    assign q0   = dp_q[0];
    assign q_m1 = dp_qm1;

    always @(posedge clk) begin
        if (ctl_load) begin
            dp_m   <= op_m;
            dp_a   <= 8'h00;
            dp_q   <= op_q;
            dp_qm1 <= 1'b0;
        end else if (ctl_add) begin
            dp_a <= ctl_sub ? (dp_a - dp_m) : (dp_a + dp_m);
        end else if (ctl_shift) begin
            {dp_a, dp_q, dp_qm1} <= {dp_a[7], dp_a, dp_q};
        end
    end

    logic [6:0] outs;
    assign outs = {ctl_init, ctl_load, ctl_add, ctl_sub, ctl_shift, busy, done};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Allowed output patterns {init,load,add,sub,shift,busy,done}
    function automatic bit legal(input logic [6:0] o);
        case (o)
            7'b0000000, 7'b0000010, 7'b1100010, 7'b0010010,
            7'b0011010, 7'b0000110, 7'b0000001: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    endfunction

    // Start one multiplication and observe it up to and including the done cycle
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit hold,
                          output int done_cyc, output int n_init, output int n_add,
                          output int n_sub, output int n_shift, output int n_bad);
        op_m     = m;
        op_q     = q;
        done_cyc = -1;
        n_init   = 0;
        n_add    = 0;
        n_sub    = 0;
        n_shift  = 0;
        n_bad    = 0;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (!legal(outs)) n_bad++;
            if (ctl_init)  n_init++;
            if (ctl_add)   n_add++;
            if (ctl_sub)   n_sub++;
            if (ctl_shift) n_shift++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        int          exp_done;
        int          exp_add;
        int          exp_sub;
        logic [15:0] exp_prod;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dc, ni, na, ns, nsh, nb, cnt;
        bit seen;

        vecs[0] = '{8'd5,   8'h00, 18, 0, 0, 16'd0};
        vecs[1] = '{8'd5,   8'h03, 20, 2, 1, 16'd15};
        vecs[2] = '{8'd5,   8'hFF, 19, 1, 1, 16'hFFFB};
        vecs[3] = '{8'd3,   8'h55, 26, 8, 4, 16'h00FF};
        vecs[4] = '{8'd7,   8'h80, 19, 1, 1, 16'hFC80};
        vecs[5] = '{8'hFD,  8'h06, 20, 2, 1, 16'hFFEE};

        rst   = 1'b1;
        start = 1'b1;
        op_m  = 8'd0;
        op_q  = 8'd0;
`ifdef BOOTH_CTL_ABORT_EN
        abort = 1'b0;
`endif

        // Reset with start held high
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", int'(outs), 0);
        chk("reset_busy", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", int'(outs), 0);

        // Table of full multiplications
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].m, vecs[i].q, 1'b0, dc, ni, na, ns, nsh, nb);
            chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk($sformatf("v%0d_init_count", i), ni, 1);
            chk($sformatf("v%0d_add_count", i), na, vecs[i].exp_add);
            chk($sformatf("v%0d_sub_count", i), ns, vecs[i].exp_sub);
            chk($sformatf("v%0d_shift_count", i), nsh, 8);
            chk($sformatf("v%0d_illegal_outs", i), nb, 0);
            chk($sformatf("v%0d_product", i), int'({dp_a, dp_q}), int'(vecs[i].exp_prod));
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_after_done", i), int'(outs), 0);
        end

        // start held from the start edge through DONE: no restart, same timing
        run_op(8'd5, 8'd3, 1'b1, dc, ni, na, ns, nsh, nb);
        chk("hold_done_cycle", dc, 20);
        chk("hold_init_count", ni, 1);
        chk("hold_illegal_outs", nb, 0);
        @(posedge clk); #1;
        chk("hold_idle_after_done", int'(outs), 0);
        run_op(8'd5, 8'd3, 1'b0, dc, ni, na, ns, nsh, nb);
        chk("second_done_cycle", dc, 20);
        chk("second_init_count", ni, 1);
        chk("second_product", int'({dp_a, dp_q}), 15);
        @(posedge clk); #1;

        // Reset during the SHIFT of iteration 4
        op_m  = 8'd5;
        op_q  = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt   = 0;
        for (int k = 0; k < 40; k++) begin
            if (ctl_shift) cnt++;
            if (cnt == 4) break;
            @(posedge clk); #1;
        end
        chk("midrst_reach_shift4", cnt, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outs", int'(outs), 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_no_done", int'(seen), 0);
        run_op(8'd5, 8'd3, 1'b0, dc, ni, na, ns, nsh, nb);
        chk("midrst_restart_done", dc, 20);
        chk("midrst_restart_product", int'({dp_a, dp_q}), 15);
        @(posedge clk); #1;

`ifdef BOOTH_CTL_ABORT_EN
        // Abort in the first ARITH
        op_m  = 8'd5;
        op_q  = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (ctl_add) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reach_arith", int'(seen), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outs", int'(outs), 0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", int'(seen), 0);
`else
        // Same stimulus without an abort port runs to completion
        run_op(8'd5, 8'd3, 1'b0, dc, ni, na, ns, nsh, nb);
        chk("noabort_done_cycle", dc, 20);
        chk("noabort_product", int'({dp_a, dp_q}), 15);
        @(posedge clk); #1;
        chk("noabort_idle", int'(outs), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
